// File: rtl/com_fifo_ctrl_pkg.sv
// Shared definitions for the buffered COM responder: register selects,
// STATUS bit positions and the transmit drain state encoding.
package com_fifo_ctrl_pkg;

   localparam logic REG_DATA   = 1'b0;
   localparam logic REG_STATUS = 1'b1;

   localparam int ST_TXRDY  = 0;
   localparam int ST_RXAVL  = 1;
   localparam int ST_OVR    = 2;
   localparam int ST_TXIDLE = 3;
   localparam int ST_INTEN  = 4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_SEND  = 2'd2
   } tx_state_e;

   function automatic logic [31:0] pack_status(input logic txrdy, input logic rxavl,
                                               input logic ovr, input logic txidle,
                                               input logic inten);
      logic [31:0] w_word;
      w_word            = '0;
      w_word[ST_TXRDY]  = txrdy;
      w_word[ST_RXAVL]  = rxavl;
      w_word[ST_OVR]    = ovr;
      w_word[ST_TXIDLE] = txidle;
      w_word[ST_INTEN]  = inten;
      return w_word;
   endfunction

endpackage

// File: rtl/com_fifo_ctrl_byte_fifo.sv
// Byte-wide first-word-fall-through FIFO. A push into a full FIFO is only
// taken when a pop frees a slot in the same cycle; a pop when empty is ignored.
module com_fifo_ctrl_byte_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == FULL_CNT);
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign dout      = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; empty/full come from the counter alone.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= din;
   end

endmodule

// File: rtl/com_fifo_ctrl.sv
// Buffered memory-mapped COM responder: RX/TX byte FIFOs, STATUS/CTRL register
// and a drain FSM that hands queued bytes to the async transmitter.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   TX_IDLE  | waiting for a queued byte and an idle transmitter
//   TX_START | start pulse issued, waiting for the transmitter to go busy
//   TX_SEND  | frame in flight, waiting for the transmitter to go idle
module com_fifo_ctrl
   import com_fifo_ctrl_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_i,
   input  logic        readEnable_i,
   input  logic        mode_i,
   input  logic [31:0] dataSave_i,
   output logic [31:0] dataLoad_o,
   output logic        busy_o,
   output logic        int_o,
   input  logic        rxdReady_i,
   input  logic [7:0]  rxdData_i,
   input  logic        txdBusy_i,
   output logic        txdStart_o,
   output logic [7:0]  txdData_o
);

   tx_state_e   r_state;
   tx_state_e   w_state_nxt;
   logic        r_txd_start;
   logic        w_txd_start_nxt;
   logic [7:0]  r_txd_data;
   logic [7:0]  w_txd_data_nxt;
   logic        r_overrun;
   logic        r_int_en;

   logic        w_rx_empty;
   logic        w_rx_full;
   logic [7:0]  w_rx_head;
   logic        w_tx_empty;
   logic        w_tx_full;
   logic [7:0]  w_tx_head;

   logic        w_data_rd;
   logic        w_data_wr;
   logic        w_ctrl_wr;
   logic        w_tx_pop;
   logic        w_rx_drop;
   logic        w_tx_idle;
   logic [31:0] w_status;
   logic        w_unused_wdata;

   assign w_data_rd = enable_i &  readEnable_i & (mode_i == REG_DATA);
   assign w_data_wr = enable_i & ~readEnable_i & (mode_i == REG_DATA);
   assign w_ctrl_wr = enable_i & ~readEnable_i & (mode_i == REG_STATUS);

   assign w_tx_pop  = (r_state == TX_IDLE) & ~w_tx_empty & ~txdBusy_i;
   // A drain pop in the same cycle frees the slot, so the write need not stall.
   assign busy_o    = w_data_wr & w_tx_full & ~w_tx_pop;
   assign w_rx_drop = rxdReady_i & w_rx_full & ~w_data_rd;
   assign w_tx_idle = w_tx_empty & (r_state == TX_IDLE) & ~txdBusy_i;

   assign w_status   = pack_status(~w_tx_full, ~w_rx_empty, r_overrun, w_tx_idle, r_int_en);
   assign dataLoad_o = (mode_i == REG_STATUS) ? w_status
                     : (w_rx_empty ? 32'd0 : {24'd0, w_rx_head});
   assign int_o      = r_int_en & ~w_rx_empty;
   assign txdStart_o = r_txd_start;
   assign txdData_o  = r_txd_data;

   assign w_unused_wdata = |dataSave_i[31:8];

   com_fifo_ctrl_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rxdReady_i),
      .pop   (w_data_rd),
      .din   (rxdData_i),
      .dout  (w_rx_head),
      .empty (w_rx_empty),
      .full  (w_rx_full)
   );

   com_fifo_ctrl_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_data_wr),
      .pop   (w_tx_pop),
      .din   (dataSave_i[7:0]),
      .dout  (w_tx_head),
      .empty (w_tx_empty),
      .full  (w_tx_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
         r_int_en  <= 1'b1;
      end else begin
         if (w_ctrl_wr) r_int_en <= dataSave_i[ST_INTEN];
         // A new drop wins over a same-cycle clear so no loss goes unreported.
         if (w_rx_drop)
            r_overrun <= 1'b1;
         else if (w_ctrl_wr && dataSave_i[ST_OVR])
            r_overrun <= 1'b0;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_txd_start_nxt = 1'b0;
      w_txd_data_nxt  = r_txd_data;
      case (r_state)
         TX_IDLE: begin
            if (w_tx_pop) begin
               w_state_nxt     = TX_START;
               w_txd_start_nxt = 1'b1;
               w_txd_data_nxt  = w_tx_head;
            end
         end
         TX_START: if (txdBusy_i)  w_state_nxt = TX_SEND;
         TX_SEND:  if (!txdBusy_i) w_state_nxt = TX_IDLE;
         default:  w_state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= TX_IDLE;
         r_txd_start <= 1'b0;
         r_txd_data  <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_txd_start <= w_txd_start_nxt;
         r_txd_data  <= w_txd_data_nxt;
      end
   end

endmodule

// File: tb/tb_com_fifo_ctrl.sv
// Self-checking bench for com_fifo_ctrl: directed steps plus a randomized
// phase, checked against queue-based RX/TX models and a transmitter model.
module tb_com_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_i;
   logic        readEnable_i;
   logic        mode_i;
   logic [31:0] dataSave_i;
   logic [31:0] dataLoad_o;
   logic        busy_o;
   logic        int_o;
   logic        rxdReady_i;
   logic [7:0]  rxdData_i;
   logic        txdBusy_i;
   logic        txdStart_o;
   logic [7:0]  txdData_o;

   always #5 clk = ~clk;

   com_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .readEnable_i (readEnable_i),
      .mode_i       (mode_i),
      .dataSave_i   (dataSave_i),
      .dataLoad_o   (dataLoad_o),
      .busy_o       (busy_o),
      .int_o        (int_o),
      .rxdReady_i   (rxdReady_i),
      .rxdData_i    (rxdData_i),
      .txdBusy_i    (txdBusy_i),
      .txdStart_o   (txdStart_o),
      .txdData_o    (txdData_o)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_tx[$];
   logic [7:0] tx_seen[$];
   bit         m_ovr   = 1'b0;
   bit         m_inten = 1'b1;

   bit         tx_hold  = 1'b0;
   bit         chk_hold = 1'b1;
   int         tx_cnt   = 0;
   logic [7:0] tx_cur   = 8'd0;

   assign txdBusy_i = tx_hold | (tx_cnt != 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Transmitter model: busy for 10 cycles after each start pulse.
   always @(negedge clk) begin
      if (txdStart_o === 1'b1) begin
         tx_seen.push_back(txdData_o);
         tx_cur = txdData_o;
         tx_cnt = 10;
      end else if (tx_cnt != 0) begin
         if (chk_hold) check("txd_data_hold", {24'd0, txdData_o}, {24'd0, tx_cur});
         tx_cnt--;
      end
   end

   function automatic logic [31:0] model_status(input bit txrdy, input bit txidle);
      return {27'd0, m_inten, txidle, m_ovr, (rx_q.size() != 0), txrdy};
   endfunction

   task automatic rx_model_push(input logic [7:0] d);
      if (rx_q.size() < 16) rx_q.push_back(d);
      else m_ovr = 1'b1;
   endtask

   task automatic model_reset();
      rx_q.delete();
      m_ovr   = 1'b0;
      m_inten = 1'b1;
   endtask

   // Called just after a rising edge; holds the access while busy_o is high.
   task automatic bus(input bit rd, input bit md, input logic [31:0] wd,
                      output logic [31:0] rdat, output int stall);
      stall        = 0;
      enable_i     = 1'b1;
      readEnable_i = rd;
      mode_i       = md;
      dataSave_i   = wd;
      @(negedge clk);
      while (busy_o === 1'b1 && stall < 300) begin
         @(negedge clk);
         stall++;
      end
      if (stall >= 300) check("bus_stall_timeout", {31'd0, busy_o}, 32'd0);
      rdat = dataLoad_o;
      @(posedge clk);
      #1;
      enable_i     = 1'b0;
      readEnable_i = 1'b0;
      mode_i       = 1'b0;
      dataSave_i   = '0;
      rxdReady_i   = 1'b0;
   endtask

   task automatic rx_pulse(input logic [7:0] d);
      rxdReady_i = 1'b1;
      rxdData_i  = d;
      @(posedge clk);
      #1;
      rxdReady_i = 1'b0;
      rx_model_push(d);
   endtask

   task automatic rd_data(input string tag, input bit with_rx, input logic [7:0] d);
      logic [31:0] r;
      logic [31:0] e;
      int          st;
      if (with_rx) begin
         rxdReady_i = 1'b1;
         rxdData_i  = d;
      end
      bus(1'b1, 1'b0, 32'd0, r, st);
      if (rx_q.size() != 0) e = {24'd0, rx_q.pop_front()};
      else e = 32'd0;
      if (with_rx) rx_model_push(d);
      check(tag, r, e);
   endtask

   task automatic rd_status(input string tag, input logic [31:0] mask, input logic [31:0] e);
      logic [31:0] r;
      int          st;
      bus(1'b1, 1'b1, 32'd0, r, st);
      check(tag, r & mask, e & mask);
   endtask

   task automatic wr_ctrl(input logic [31:0] wd);
      logic [31:0] r;
      int          st;
      bus(1'b0, 1'b1, wd, r, st);
      m_inten = wd[4];
      if (wd[2]) m_ovr = 1'b0;
   endtask

   task automatic wr_data(input logic [7:0] d, output int stall);
      logic [31:0] r;
      logic [31:0] wd;
      wd      = $urandom;
      wd[7:0] = d;
      bus(1'b0, 1'b0, wd, r, stall);
      exp_tx.push_back(d);
   endtask

   task automatic wait_tx_idle(input string tag);
      int n = 0;
      while (!(tx_cnt == 0 && !tx_hold && tx_seen.size() == exp_tx.size() && txdStart_o == 1'b0)
             && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_count"}, tx_seen.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size() && i < tx_seen.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), {24'd0, tx_seen[i]}, {24'd0, exp_tx[i]});
      exp_tx.delete();
      tx_seen.delete();
   endtask

   initial begin
      int          st;
      logic [7:0]  d;
      int          op;
      logic [31:0] wd;

      rst          = 1'b1;
      enable_i     = 1'b0;
      readEnable_i = 1'b0;
      mode_i       = 1'b0;
      dataSave_i   = '0;
      rxdReady_i   = 1'b0;
      rxdData_i    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst_int", {31'd0, int_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_txd_start", {31'd0, txdStart_o}, 32'd0);
      check("rst_txd_data", {24'd0, txdData_o}, 32'd0);
      rd_status("rst_status", 32'hFFFF_FFFF, 32'h19);
      rd_data("rst_data", 1'b0, 8'd0);

      // RX ordering and interrupt
      rx_pulse(8'h41);
      rx_pulse(8'h42);
      check("rx_int_set", {31'd0, int_o}, 32'd1);
      rd_status("rx_status", 32'hFFFF_FFFF, model_status(1'b1, 1'b1));
      rd_data("rx_first", 1'b0, 8'd0);
      rd_data("rx_second", 1'b0, 8'd0);
      check("rx_int_clear", {31'd0, int_o}, 32'd0);

      // RX overrun
      for (int i = 0; i < 17; i++) rx_pulse(8'(i));
      rd_status("ovr_status", 32'hFFFF_FFFF, 32'h1F);
      for (int i = 0; i < 16; i++) rd_data($sformatf("ovr_rd%0d", i), 1'b0, 8'd0);
      rd_data("ovr_rd_empty", 1'b0, 8'd0);
      wr_ctrl(32'h14);
      rd_status("ovr_cleared", 32'hFFFF_FFFF, 32'h19);

      // RX full with simultaneous pop and receive: stored, no overrun
      for (int i = 0; i < 16; i++) rx_pulse(8'(8'h80 + i));
      rd_data("full_pop_push", 1'b1, 8'hC3);
      rd_status("full_pop_push_status", 32'hFFFF_FFFF, model_status(1'b1, 1'b1));
      while (rx_q.size() != 0) rd_data("full_drain", 1'b0, 8'd0);
      rd_data("empty_pop_push", 1'b1, 8'h5A);
      rd_data("empty_pop_push_stored", 1'b0, 8'd0);

      // TX drain
      wr_data(8'h55, st);
      wr_data(8'hAA, st);
      wait_tx_idle("tx_drain");
      rd_status("tx_idle_status", 32'hFFFF_FFFF, model_status(1'b1, 1'b1));

      // TX backpressure
      tx_hold = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_data(8'(8'h60 + i), st);
         check($sformatf("bp_nostall%0d", i), st, 0);
      end
      rd_status("bp_full_status", 32'hFFFF_FFFF, model_status(1'b0, 1'b0));
      enable_i     = 1'b1;
      readEnable_i = 1'b0;
      mode_i       = 1'b0;
      dataSave_i   = 32'h0000_00E7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("bp_busy%0d", i), {31'd0, busy_o}, 32'd1);
      end
      tx_hold = 1'b0;
      #1;
      check("bp_release", {31'd0, busy_o}, 32'd0);
      @(posedge clk);
      #1;
      enable_i   = 1'b0;
      dataSave_i = '0;
      exp_tx.push_back(8'hE7);
      wait_tx_idle("bp_stream");

      // Interrupt mask
      wr_ctrl(32'h00);
      rx_pulse(8'h31);
      check("mask_int_off", {31'd0, int_o}, 32'd0);
      rd_status("mask_status", 32'hFFFF_FFFF, 32'h0B);
      wr_ctrl(32'h10);
      check("mask_int_on", {31'd0, int_o}, 32'd1);
      rd_data("mask_read", 1'b0, 8'd0);

      // Randomized mix of RX, reads, CTRL writes and TX writes
      for (int it = 0; it < 400; it++) begin
         check("rnd_int", {31'd0, int_o}, {31'd0, (m_inten && rx_q.size() != 0)});
         op = $urandom_range(0, 6);
         d  = 8'($urandom);
         case (op)
            0, 1: rx_pulse(d);
            2:    rd_data("rnd_rd", $urandom_range(0, 1) == 1, d);
            3:    rd_status("rnd_status", 32'hFFFF_FFF6, model_status(1'b0, 1'b0));
            4: begin
               wd = $urandom;
               if ($urandom_range(0, 3) != 0) wd[4] = 1'b1;
               wr_ctrl(wd);
            end
            5:    wr_data(d, st);
            default: begin
               @(posedge clk);
               #1;
            end
         endcase
      end
      wait_tx_idle("rnd_stream");
      rd_status("rnd_final_status", 32'hFFFF_FFFF, model_status(1'b1, 1'b1));

      // Reset mid-frame: queued byte flushed, frame in flight completes
      wr_data(8'h11, st);
      wr_data(8'h22, st);
      @(posedge clk);
      #1;
      chk_hold = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      void'(exp_tx.pop_back());
      check("mid_rst_busy_seen", {31'd0, txdBusy_i}, 32'd1);
      check("mid_rst_txd_data", {24'd0, txdData_o}, 32'd0);
      check("mid_rst_txd_start", {31'd0, txdStart_o}, 32'd0);
      rd_status("mid_rst_status", 32'hFFFF_FFFF, 32'h11);
      wait_tx_idle("mid_rst_stream");
      chk_hold = 1'b1;
      rd_status("post_rst_status", 32'hFFFF_FFFF, 32'h19);
      wr_data(8'h77, st);
      wait_tx_idle("post_rst_stream");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
